sync_fifo_mc: RTL and testbench



---
 rtl/sync_fifo_mc.sv | 131 +++++++++++++
 tb/tb_sync_fifo_mc.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_mc.sv
// sync_fifo_mc: NUM_CH independent FIFOs sharing one write and one read port.
// Define SYNC_FIFO_MC_FWFT_EN for first-word fall-through reads.
module sync_fifo_mc #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 9,
  parameter int NUM_CH   = 4,
  parameter int CHW      = $clog2(NUM_CH),
  parameter int AF_LEVEL = 2**ADDRSIZE-4,
  parameter int AE_LEVEL = 4
) (
  input  logic                         wclk,
  input  logic                         w_rst,
  input  logic                         wr_en,
  input  logic [CHW-1:0]               wr_ch,
  input  logic [DATASIZE-1:0]          wdata,
  input  logic                         rd_en,
  input  logic [CHW-1:0]               rd_ch,
  output logic [DATASIZE-1:0]          rdata,
  output logic                         rvalid,
  output logic [NUM_CH-1:0]            full,
  output logic [NUM_CH-1:0]            empty,
  output logic [NUM_CH-1:0]            almost_full,
  output logic [NUM_CH-1:0]            almost_empty,
  output logic [NUM_CH*(ADDRSIZE+1)-1:0] count,
  output logic [NUM_CH-1:0]            overflow,
  output logic [NUM_CH-1:0]            underflow
);

  localparam int DEPTH = 2**ADDRSIZE;
  localparam int PW    = ADDRSIZE + 1;
  localparam int MW    = CHW + ADDRSIZE;

  localparam logic [PW-1:0] P_ONE = PW'(1);
  localparam logic [PW-1:0] AF_L  = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_L  = PW'(AE_LEVEL);
  localparam logic [CHW:0]  CH_N  = (CHW+1)'(NUM_CH);

  logic [DATASIZE-1:0] mem [NUM_CH*DEPTH];

  logic [PW-1:0] wptr [NUM_CH];
  logic [PW-1:0] rptr [NUM_CH];
  logic [PW-1:0] cnt  [NUM_CH];

  logic          wch_ok;
  logic          rch_ok;
  logic          wr_hit;
  logic          rd_hit;
  logic          wr_ok;
  logic          rd_ok;
  logic [MW-1:0] waddr;
  logic [MW-1:0] raddr;

  // Requests to a channel number beyond NUM_CH are ignored.
  assign wch_ok = ({1'b0, wr_ch} < CH_N);
  assign rch_ok = ({1'b0, rd_ch} < CH_N);

  assign wr_hit = wr_en && wch_ok;
  assign rd_hit = rd_en && rch_ok;

  // Boundary checks use the pre-edge flags, so a same-channel
  // pop never makes room for a write into a full queue.
  assign wr_ok = wr_hit && !full[wr_ch];
  assign rd_ok = rd_hit && !empty[rd_ch];

  assign waddr = {wr_ch, wptr[wr_ch][ADDRSIZE-1:0]};
  assign raddr = {rd_ch, rptr[rd_ch][ADDRSIZE-1:0]};

  // Status flags and occupancy derived from the pointer pair.
  always_comb begin
    count        = '0;
    full         = '0;
    empty        = '0;
    almost_full  = '0;
    almost_empty = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      cnt[c]          = wptr[c] - rptr[c];
      empty[c]        = (wptr[c] == rptr[c]);
      full[c]         = (wptr[c][ADDRSIZE-1:0] == rptr[c][ADDRSIZE-1:0])
                     && (wptr[c][ADDRSIZE] != rptr[c][ADDRSIZE]);
      almost_full[c]  = (cnt[c] >= AF_L);
      almost_empty[c] = (cnt[c] <= AE_L);
      count[c*PW +: PW] = cnt[c];
    end
  end

  // Pointer advance and sticky error capture.
  always_ff @(posedge wclk) begin
    if (w_rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wptr[c] <= '0;
        rptr[c] <= '0;
      end
      overflow  <= '0;
      underflow <= '0;
    end else begin
      if (wr_ok)
        wptr[wr_ch] <= wptr[wr_ch] + P_ONE;
      if (rd_ok)
        rptr[rd_ch] <= rptr[rd_ch] + P_ONE;
      if (wr_hit && full[wr_ch])
        overflow[wr_ch] <= 1'b1;
      if (rd_hit && empty[rd_ch])
        underflow[rd_ch] <= 1'b1;
    end
  end

  // Storage write; contents survive reset.
  always_ff @(posedge wclk) begin
    if (!w_rst && wr_ok)
      mem[waddr] <= wdata;
  end

`ifdef SYNC_FIFO_MC_FWFT_EN
  // Head word of the selected channel is always presented.
  assign rdata  = mem[raddr];
  assign rvalid = rch_ok && !empty[rd_ch];
`else
  // Registered read: data one cycle after the accepted pop.
  always_ff @(posedge wclk) begin
    if (w_rst) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_ok;
      if (rd_ok)
        rdata <= mem[raddr];
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_mc.sv
// tb_sync_fifo_mc: scoreboard bench for sync_fifo_mc.
// DEPTH=16, four channels, AF=12, AE=4.
module tb_sync_fifo_mc;

  localparam int DW  = 8;
  localparam int AW  = 4;
  localparam int NCH = 4;
  localparam int CW  = 2;
  localparam int PW  = AW + 1;
  localparam int D   = 16;

  logic              clk = 1'b0;
  logic              w_rst;
  logic              wr_en;
  logic [CW-1:0]     wr_ch;
  logic [DW-1:0]     wdata;
  logic              rd_en;
  logic [CW-1:0]     rd_ch;
  logic [DW-1:0]     rdata;
  logic              rvalid;
  logic [NCH-1:0]    full;
  logic [NCH-1:0]    empty;
  logic [NCH-1:0]    almost_full;
  logic [NCH-1:0]    almost_empty;
  logic [NCH*PW-1:0] count;
  logic [NCH-1:0]    overflow;
  logic [NCH-1:0]    underflow;

  int n_run  = 0;
  int n_fail = 0;

  logic [7:0]     mdat [NCH][D];
  int             mhd  [NCH];
  int             mcnt [NCH];
  logic [NCH-1:0] mov;
  logic [NCH-1:0] mun;
  logic [7:0]     exp_q [$];

  sync_fifo_mc #(
    .DATASIZE (DW),
    .ADDRSIZE (AW),
    .NUM_CH   (NCH),
    .AF_LEVEL (12),
    .AE_LEVEL (4)
  ) dut (
    .wclk         (clk),
    .w_rst        (w_rst),
    .wr_en        (wr_en),
    .wr_ch        (wr_ch),
    .wdata        (wdata),
    .rd_en        (rd_en),
    .rd_ch        (rd_ch),
    .rdata        (rdata),
    .rvalid       (rvalid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h exp=%0h",
               tag, $time, got, exp);
    end
  endtask

  task automatic chk_flags();
    logic [NCH-1:0]    e_full;
    logic [NCH-1:0]    e_empty;
    logic [NCH-1:0]    e_af;
    logic [NCH-1:0]    e_ae;
    logic [NCH*PW-1:0] e_cnt;
    e_full  = '0;
    e_empty = '0;
    e_af    = '0;
    e_ae    = '0;
    e_cnt   = '0;
    for (int c = 0; c < NCH; c++) begin
      e_full[c]  = (mcnt[c] == D);
      e_empty[c] = (mcnt[c] == 0);
      e_af[c]    = (mcnt[c] >= 12);
      e_ae[c]    = (mcnt[c] <= 4);
      e_cnt[c*PW +: PW] = PW'(mcnt[c]);
    end
    chk("count", 32'(count), 32'(e_cnt));
    chk("full", 32'(full), 32'(e_full));
    chk("empty", 32'(empty), 32'(e_empty));
    chk("almost_full", 32'(almost_full), 32'(e_af));
    chk("almost_empty", 32'(almost_empty), 32'(e_ae));
    chk("overflow", 32'(overflow), 32'(mov));
    chk("underflow", 32'(underflow), 32'(mun));
  endtask

  task automatic step(input logic we, input int wc,
                      input logic [7:0] wd,
                      input logic re, input int rc,
                      input logic rs);
    logic       wok;
    logic       rok;
    logic [7:0] v;
    w_rst = rs;
    wr_en = we;
    wr_ch = CW'(wc);
    wdata = wd;
    rd_en = re;
    rd_ch = CW'(rc);
    #1;
`ifdef SYNC_FIFO_MC_FWFT_EN
    if (!rs) begin
      chk("fwft_rvalid", 32'(rvalid), 32'(mcnt[rc] > 0));
      if (mcnt[rc] > 0)
        chk("fwft_rdata", 32'(rdata), 32'(mdat[rc][mhd[rc]]));
    end
`endif
    @(posedge clk);
    if (rs) begin
      for (int c = 0; c < NCH; c++) begin
        mhd[c]  = 0;
        mcnt[c] = 0;
      end
      mov = '0;
      mun = '0;
      exp_q.delete();
    end else begin
      wok = we && (mcnt[wc] < D);
      rok = re && (mcnt[rc] > 0);
      if (we && !wok) mov[wc] = 1'b1;
      if (re && !rok) mun[rc] = 1'b1;
      if (rok) begin
        v = mdat[rc][mhd[rc]];
`ifndef SYNC_FIFO_MC_FWFT_EN
        exp_q.push_back(v);
`endif
        mhd[rc]  = (mhd[rc] + 1) % D;
        mcnt[rc] = mcnt[rc] - 1;
      end
      if (wok) begin
        mdat[wc][(mhd[wc] + mcnt[wc]) % D] = wd;
        mcnt[wc] = mcnt[wc] + 1;
      end
    end
    #1;
`ifndef SYNC_FIFO_MC_FWFT_EN
    if (exp_q.size() > 0) begin
      chk("rvalid", 32'(rvalid), 32'd1);
      chk("rdata", 32'(rdata), 32'(exp_q.pop_front()));
    end else begin
      chk("rvalid_idle", 32'(rvalid), 32'd0);
    end
    if (rs)
      chk("rdata_rst", 32'(rdata), 32'd0);
`endif
    chk_flags();
  endtask

  task automatic idle(input int rc);
    step(1'b0, 0, 8'h00, 1'b0, rc, 1'b0);
  endtask

  initial begin
    w_rst = 1'b1;
    wr_en = 1'b0;
    wr_ch = '0;
    wdata = '0;
    rd_en = 1'b0;
    rd_ch = '0;
    mov   = '0;
    mun   = '0;

    step(1'b0, 0, 8'h00, 1'b0, 0, 1'b1);
    step(1'b0, 0, 8'h00, 1'b0, 0, 1'b1);

    for (int i = 0; i < 17; i++)
      step(1'b1, 2, 8'(8'h10 + i), 1'b0, 2, 1'b0);
    for (int i = 0; i < 17; i++)
      step(1'b0, 0, 8'h00, 1'b1, 2, 1'b0);
    idle(2);

    step(1'b1, 1, 8'h55, 1'b0, 1, 1'b0);
    step(1'b1, 0, 8'hA0, 1'b1, 1, 1'b0);
    idle(1);

    for (int i = 0; i < 16; i++)
      step(1'b1, 3, 8'(8'h30 + i), 1'b0, 3, 1'b0);
    step(1'b1, 3, 8'hEE, 1'b1, 3, 1'b0);
    idle(3);

    step(1'b1, 1, 8'h77, 1'b1, 1, 1'b0);
    step(1'b0, 0, 8'h00, 1'b1, 1, 1'b0);
    idle(1);

    for (int i = 0; i < 40; i++)
      step(1'b1, 0, 8'(8'h80 + i), 1'b1, 0, 1'b0);
    for (int i = 0; i < 4; i++)
      step(1'b1, 0, 8'(8'hC0 + i), 1'b0, 0, 1'b0);
    step(1'b1, 0, 8'hDD, 1'b1, 0, 1'b1);
    idle(0);
    step(1'b1, 0, 8'h3C, 1'b0, 0, 1'b0);
    idle(0);
    idle(0);

    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)),
           int'($urandom_range(0, NCH-1)),
           8'($urandom),
           1'($urandom_range(0, 1)),
           int'($urandom_range(0, NCH-1)),
           1'($urandom_range(0, 99) == 0));
    idle(0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
